// File: rtl/leddc_pkg.sv
// -----------------------------------------------------------------------------
// leddc_pkg
//   Constants and types shared by the LEDDC frame transmitter and receiver.
//   WORD_W        : bits per pixel word on the serial link
//   WORDS_DEFAULT : words per frame (32 scanlines x 16 channels)
//   GAP_DEFAULT   : DEN-low DCK cycles between consecutive words
//   leddc_state_e : frame-level FSM state encoding
// -----------------------------------------------------------------------------
package leddc_pkg;

  localparam int WORD_W        = 16;
  localparam int WORDS_DEFAULT = 512;
  localparam int GAP_DEFAULT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } leddc_state_e;

endpackage

// File: rtl/leddc_tx_serializer.sv
// -----------------------------------------------------------------------------
// leddc_tx_serializer
//   16-bit parallel-load, shift-right register; the serial output is bit 0,
//   so words leave LSB first. Zeros are shifted in from the top, which means
//   the register is empty (DAI low) once all 16 bits have been sent.
// Ports:
//   DCK       in   clock
//   rst       in   synchronous active-low reset (clears the register)
//   load      in   load load_data at the next edge (has priority over shift)
//   load_data in   word to serialize
//   shift     in   shift right by one at the next edge
//   dai       out  serial data, register bit 0
// -----------------------------------------------------------------------------
module leddc_tx_serializer
  import leddc_pkg::*;
(
  input  logic              DCK,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic              dai
);

  logic [WORD_W-1:0] shift_reg;

  always_ff @(posedge DCK) begin
    if (!rst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= load_data;
    end else if (shift) begin
      shift_reg <= {1'b0, shift_reg[WORD_W-1:1]};
    end
  end

  assign dai = shift_reg[0];

endmodule

// File: rtl/leddc_frame_tx.sv
// -----------------------------------------------------------------------------
// leddc_frame_tx
//   Reads a frame of WORDS 16-bit words from a synchronous frame memory and
//   sends each one LSB first on DAI while DEN is high, with GAP DEN-low cycles
//   between words. The next word is prefetched during the last SHIFT cycle so
//   the inter-word gap stays exactly GAP cycles.
// Parameters:
//   WORDS  words per frame
//   GAP    DEN-low cycles between words (1..15)
// Ports:
//   DCK      in   clock, all state changes on its rising edge
//   rst      in   synchronous active-low reset
//   start    in   frame request, only looked at while idle
//   rd_en    out  one-cycle read strobe to the frame memory
//   rd_addr  out  word index being read
//   rd_data  in   memory data, valid the cycle after rd_en
//   DAI      out  serial pixel data
//   DEN      out  data enable, high while a word is on DAI
//   busy     out  high whenever the FSM is not idle
//   done     out  one-cycle pulse at the end of a frame
// -----------------------------------------------------------------------------
module leddc_frame_tx
  import leddc_pkg::*;
#(
  parameter  int WORDS  = WORDS_DEFAULT,
  parameter  int GAP    = GAP_DEFAULT,
  localparam int ADDR_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              DCK,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              DAI,
  output logic              DEN,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(WORDS - 1);
  localparam logic [3:0]        GAP_LAST  = 4'(GAP - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(WORD_W - 1);
  localparam logic [3:0]        BIT_PREF  = 4'(WORD_W - 2);

  leddc_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [3:0]        gap_cnt_reg, gap_cnt_next;
  logic              rd_en_reg, rd_en_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic              den_reg, den_next;
  logic              done_reg, done_next;

  // rd_data is only guaranteed for the one cycle after a strobe, so it is
  // copied into hold_reg then and reused if the load happens later.
  logic              data_vld_reg;
  logic [WORD_W-1:0] hold_reg;
  logic [WORD_W-1:0] load_data;
  logic              load;
  logic              shift;

  assign load_data = data_vld_reg ? rd_data : hold_reg;

  always_ff @(posedge DCK) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      bit_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      rd_en_reg    <= 1'b0;
      rd_addr_reg  <= '0;
      den_reg      <= 1'b0;
      done_reg     <= 1'b0;
      data_vld_reg <= 1'b0;
      hold_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      bit_cnt_reg  <= bit_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      rd_en_reg    <= rd_en_next;
      rd_addr_reg  <= rd_addr_next;
      den_reg      <= den_next;
      done_reg     <= done_next;
      data_vld_reg <= rd_en_reg;
      if (data_vld_reg) begin
        hold_reg <= rd_data;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    rd_addr_next = rd_addr_reg;
    rd_en_next   = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          idx_next   = '0;
        end
      end
      ST_FETCH: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next   = ST_SHIFT;
        load         = 1'b1;
        bit_cnt_next = '0;
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (bit_cnt_reg == BIT_LAST) begin
          state_next   = ST_GAP;
          gap_cnt_next = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + 4'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            state_next   = ST_SHIFT;
            load         = 1'b1;
            idx_next     = idx_reg + ADDR_W'(1);
            bit_cnt_next = '0;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so each one
    // is a flop output that moves only on the clock edge.
    if (state_next == ST_FETCH) begin
      rd_en_next   = 1'b1;
      rd_addr_next = idx_next;
    end else if (state_reg == ST_SHIFT && bit_cnt_reg == BIT_PREF &&
                 idx_reg != LAST_IDX) begin
      // entering the last shift cycle of a word: prefetch the next one
      rd_en_next   = 1'b1;
      rd_addr_next = idx_reg + ADDR_W'(1);
    end
  end

  assign den_next  = (state_next == ST_SHIFT);
  assign done_next = (state_next == ST_DONE);

  leddc_tx_serializer u_serializer (
    .DCK       (DCK),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .shift     (shift),
    .dai       (DAI)
  );

  assign rd_en   = rd_en_reg;
  assign rd_addr = rd_addr_reg;
  assign DEN     = den_reg;
  assign done    = done_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_leddc_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_leddc_frame_tx
//   Three transmitter instances run side by side:
//     inst 0: WORDS=512 GAP=2, mem[i]=i
//     inst 1: WORDS=1   GAP=2, mem[0]=A5C3
//     inst 2: WORDS=4   GAP=1, mem={FFFF,0000,8001,7FFE}
//   Issuing a frame pushes its expected words; a per-instance monitor rebuilds
//   words from DEN/DAI and pops/compares them, and also checks latency, word
//   width, inter-word gap, read addresses and done timing.
// -----------------------------------------------------------------------------
module tb_leddc_frame_tx;
  import leddc_pkg::*;

  localparam int N_INST = 3;

  function automatic int words_of(input int k);
    case (k)
      0:       return 512;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int gap_of(input int k);
    case (k)
      0, 1:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] mem_val(input int k, input int a);
    logic [15:0] tbl [4];
    tbl = '{16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE};
    case (k)
      0:       return 16'(a);
      1:       return 16'hA5C3;
      default: return tbl[a % 4];
    endcase
  endfunction

  logic clk = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic start  [N_INST];
  logic rst_n  [N_INST];
  logic rd_en  [N_INST];
  logic dai    [N_INST];
  logic den    [N_INST];
  logic busy   [N_INST];
  logic done   [N_INST];

  int n_tests = 0;
  int n_fail  = 0;

  int start_cyc [N_INST] = '{default: 0};
  int issued    [N_INST] = '{default: 0};
  int aborted   [N_INST] = '{default: 0};
  int finished  [N_INST] = '{default: 0};
  int rd_cnt    [N_INST] = '{default: 0};
  int rd_total  [N_INST] = '{default: 0};

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic bit active(input int k);
    return issued[k] > finished[k] + aborted[k];
  endfunction

  task automatic check_word(input int k, input logic [15:0] w);
    logic [15:0] e;
    if (qsize(k) == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL word_extra inst%0d: got 0x%04h, no word expected (cycle %0d)", k, w, cyc);
    end else begin
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("word_inst%0d", k), int'(w), int'(e));
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < N_INST; gi++) begin : g_inst
      localparam int W  = words_of(gi);
      localparam int G  = gap_of(gi);
      localparam int AW = (W > 1) ? $clog2(W) : 1;

      logic [AW-1:0] rd_addr;
      logic [15:0]   rd_data;

      leddc_frame_tx #(.WORDS(W), .GAP(G)) u_dut (
        .DCK     (clk),
        .rst     (rst_n[gi]),
        .start   (start[gi]),
        .rd_en   (rd_en[gi]),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .DAI     (dai[gi]),
        .DEN     (den[gi]),
        .busy    (busy[gi]),
        .done    (done[gi])
      );

      // Registered-read memory; data is valid for one cycle only, garbage after.
      always @(posedge clk) begin
        if (rd_en[gi]) rd_data <= mem_val(gi, int'(rd_addr));
        else           rd_data <= 16'($urandom);
      end

      logic [15:0] sh         = '0;
      logic        den_prev   = 1'b0;
      int          high_run   = 0;
      int          low_run    = 0;
      int          words_seen = 0;
      int          den_fall   = 0;

      always @(negedge clk) begin
        if (!rst_n[gi]) begin
          high_run   = 0;
          low_run    = 0;
          words_seen = 0;
          den_prev   = 1'b0;
          rd_cnt[gi] = 0;
        end else begin
          if (rd_en[gi]) begin
            check($sformatf("rd_en_active_inst%0d", gi), int'(active(gi)), 1);
            check($sformatf("rd_addr_inst%0d", gi), int'(rd_addr), rd_cnt[gi]);
            rd_cnt[gi]++;
            rd_total[gi]++;
          end
          if (den[gi]) begin
            if (!den_prev) begin
              check($sformatf("den_active_inst%0d", gi), int'(active(gi)), 1);
              if (words_seen == 0)
                check($sformatf("den_latency_inst%0d", gi), cyc - start_cyc[gi], 2);
              else
                check($sformatf("den_gap_inst%0d", gi), low_run, G);
              high_run = 0;
            end
            sh = {dai[gi], sh[15:1]};
            high_run++;
            if (high_run == 16) begin
              check_word(gi, sh);
              words_seen++;
            end
          end else begin
            if (den_prev) begin
              check($sformatf("den_width_inst%0d", gi), high_run, 16);
              den_fall = cyc;
              low_run  = 0;
            end
            low_run++;
            if (active(gi))
              check($sformatf("dai_den_low_inst%0d", gi), int'(dai[gi]), 0);
          end
          if (done[gi]) begin
            check($sformatf("done_active_inst%0d", gi), int'(active(gi)), 1);
            check($sformatf("done_edge_inst%0d", gi), cyc - start_cyc[gi], 2 + W * (16 + G));
            check($sformatf("done_after_den_inst%0d", gi), cyc - den_fall, G);
            check($sformatf("rd_count_inst%0d", gi), rd_cnt[gi], W);
            check($sformatf("words_seen_inst%0d", gi), words_seen, W);
            check($sformatf("words_left_inst%0d", gi), qsize(gi), 0);
            finished[gi]++;
            words_seen = 0;
            rd_cnt[gi] = 0;
          end
          den_prev = den[gi];
        end
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k);
    start[k]     = 1'b1;
    start_cyc[k] = cyc + 1;
    issued[k]++;
    for (int i = 0; i < words_of(k); i++) begin
      case (k)
        0:       q0.push_back(mem_val(k, i));
        1:       q1.push_back(mem_val(k, i));
        default: q2.push_back(mem_val(k, i));
      endcase
    end
  endtask

  task automatic wait_finished(input int k, input int n, input int limit);
    int t;
    t = 0;
    while (finished[k] < n && t < limit) begin
      tick();
      t++;
    end
    check($sformatf("frame_finished_inst%0d", k), finished[k], n);
  endtask

  task automatic check_idle(input string tag, input int k);
    check($sformatf("%s_busy_inst%0d", tag, k),  int'(busy[k]),  0);
    check($sformatf("%s_den_inst%0d", tag, k),   int'(den[k]),   0);
    check($sformatf("%s_dai_inst%0d", tag, k),   int'(dai[k]),   0);
    check($sformatf("%s_rd_en_inst%0d", tag, k), int'(rd_en[k]), 0);
    check($sformatf("%s_done_inst%0d", tag, k),  int'(done[k]),  0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d;
    for (int k = 0; k < N_INST; k++) begin
      start[k] = 1'b0;
      rst_n[k] = 1'b0;
    end
    repeat (3) tick();
    for (int k = 0; k < N_INST; k++) check_idle("reset", k);
    for (int k = 0; k < N_INST; k++) rst_n[k] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int k = 0; k < N_INST; k++) check_idle("post_reset", k);
    end

    // all three frames start on the same edge
    for (int k = 0; k < N_INST; k++) issue(k);
    tick();
    for (int k = 0; k < N_INST; k++) start[k] = 1'b0;
    for (int k = 0; k < N_INST; k++) check($sformatf("busy_after_start_inst%0d", k), int'(busy[k]), 1);

    // stray start on inst 0 at edge 100 of its frame
    while (cyc < start_cyc[0] + 99) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("stray_start_busy_inst0", int'(busy[0]), 1);

    wait_finished(1, 1, 200);
    wait_finished(2, 1, 200);

    // inst 2: reset in SHIFT cycle 7 of word 3, then resend
    issue(2);
    tick();
    start[2] = 1'b0;
    s = start_cyc[2];
    while (cyc < s + 60) tick();
    check("den_before_rst_inst2", int'(den[2]), 1);
    rst_n[2] = 1'b0;
    q2.delete();
    aborted[2]++;
    tick();
    check_idle("mid_word_rst", 2);
    rst_n[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle("rst_release", 2);
    end
    issue(2);
    tick();
    start[2] = 1'b0;
    wait_finished(2, 2, 200);

    // inst 0: start held during DONE must not restart
    d = start_cyc[0] + 2 + 512 * 18;
    while (cyc < d) tick();
    check("done_pulse_inst0", int'(done[0]), 1);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("done_clear_inst0", int'(done[0]), 0);
    check("busy_after_done_inst0", int'(busy[0]), 0);
    repeat (40) tick();
    check_idle("after_frame", 0);
    check("rd_total_inst0", rd_total[0], 512);
    check("frames_inst0", finished[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/leddc_frame_tx.md
LEDDC_FRAME_TX -- requirements
Module: leddc_frame_tx

Interface
REQ-001 SHALL have parameter WORDS, default 512, meaning words per frame (32 scanlines x 16 channels).
REQ-002 SHALL have parameter GAP, default 2, legal 1..15, meaning DEN-low DCK cycles between words.
REQ-003 SHALL have port DCK, input, 1 bit: the single clock; all state updates on posedge DCK.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: frame-send request, sampled in IDLE only.
REQ-006 SHALL have port rd_en, output, 1 bit: one-cycle read strobe to frame memory.
REQ-007 SHALL have port rd_addr, output, $clog2(WORDS) bits: word index being read.
REQ-008 SHALL have port rd_data, input, 16 bits: memory data, valid the cycle after rd_en.
REQ-009 SHALL have port DAI, output, 1 bit: serial pixel data, LSB first.
REQ-010 SHALL have port DEN, output, 1 bit: data enable, high while a word's 16 bits are on DAI.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-013 SHALL implement FSM IDLE -> FETCH -> LOAD -> SHIFT -> GAP -> (SHIFT | DONE) -> IDLE.
REQ-014 IDLE: DEN=0, DAI=0, rd_en=0; start=1 at an edge SHALL enter FETCH and clear the word index to 0.
REQ-015 FETCH (1 cycle): rd_en=1, rd_addr=word index; next state LOAD.
REQ-016 LOAD (1 cycle): DEN=0; rd_data SHALL be captured into the 16-bit shift register at the LOAD->SHIFT edge.
REQ-017 SHIFT (exactly 16 cycles): DEN=1, DAI=shift register bit 0; shift right by one each edge; bit k SHALL be on DAI in SHIFT cycle k.
REQ-018 In SHIFT cycle 15, if the word index is not WORDS-1: rd_en=1 and rd_addr=index+1.
REQ-019 GAP (exactly GAP cycles): DEN=0, DAI=0; the prefetched rd_data SHALL be held and loaded into the shift register at the GAP->SHIFT edge, with the index incremented.
REQ-020 After the last word's GAP, the FSM SHALL enter DONE for 1 cycle (done=1) and then IDLE.
REQ-021 Latency: with start sampled at edge 0, DEN SHALL be high from edge 2 through edge 17 (values after each edge).
REQ-022 Frame length: done SHALL be high after edge 2 + WORDS*(16+GAP); this is edge 9218 for the defaults.
REQ-023 start while busy SHALL be ignored and SHALL NOT be queued; start held high in DONE SHALL NOT restart until IDLE.
REQ-024 rd_en SHALL be asserted exactly WORDS times per frame, with addresses 0..WORDS-1 ascending, no wrap.
REQ-025 DAI, DEN, rd_en, done SHALL be driven from registers (glitch-free) and SHALL change only after posedge DCK.

Reset
REQ-026 rst=0 at any edge SHALL force IDLE, DEN=0, DAI=0, rd_en=0, done=0, busy=0, index=0 and shift register=0, including mid-word.
REQ-027 After rst releases, no output SHALL change until a new start is sampled.

Structure
REQ-028 Package leddc_pkg SHALL hold WORD_W=16, the default WORDS/GAP constants and the FSM state enum; the same package is shared with the LEDDC receiver.
REQ-029 A single sub-module, leddc_tx_serializer (16-bit load/shift register, DAI=bit0), SHALL be instantiated; the FSM and counters SHALL remain in the top module.

Verification
REQ-030 Single word (WORDS=1, GAP=2), mem[0]=16'hA5C3, start pulse: DAI over 16 DEN-high cycles = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; done 2 cycles after DEN falls.
REQ-031 Defaults, mem[i]=i: the scoreboard reassembles 512 words equal to 0..511; DEN low for exactly 2 cycles between words; done at edge 9218.
REQ-032 start pulsed again at edge 100 and at the DONE edge: no second frame begins; rd_en count = 512.
REQ-033 rst=0 in SHIFT cycle 7 of word 3: DEN=0 and busy=0 after that edge; a fresh start resends from address 0.
REQ-034 GAP=1, WORDS=4, mem={FFFF,0000,8001,7FFE}: exactly one DEN-low cycle between words; reassembled words match the memory contents.
